// File: rtl/psk_tx_pkg.sv
// Shared types and constants for the PSK transmit framer: FSM states,
// fixed frame fill bytes and the bit-to-amplitude mapping.
package psk_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        PAYLOAD,
        TAIL
    } tx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] TAIL_BYTE     = 8'h00;

    // Bit 0 -> +amp, bit 1 -> -amp.
    function automatic logic signed [11:0] bit_to_amp(input logic b,
                                                      input logic signed [11:0] amp);
        return b ? -amp : amp;
    endfunction

endpackage

// File: rtl/psk_tx_framer_if.sv
// Byte-stream payload interface feeding the PSK transmit framer.
// A byte transfers on a clock edge where s_tvalid and s_tready are both high;
// the master holds s_tdata/s_tlast stable while s_tvalid is high and unaccepted.
interface psk_tx_framer_if;

    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;

    modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
    modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);

endinterface

// File: rtl/psk_tx_mapper.sv
// Symbol mapper: turns one or two bits into registered I/Q samples.
// Build option TX_DIFF_ENC_EN enables per-rail differential encoding.
module psk_tx_mapper
    import psk_tx_pkg::*;
#(
    parameter logic signed [11:0] AMP = 12'sd1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                emit,
    input  logic                clear,
    input  logic                first,
    input  logic                bpsk,
    input  logic                b_i,
    input  logic                b_q,
    output logic signed [11:0]  dac_i,
    output logic signed [11:0]  dac_q
);

    logic e_i;
    logic e_q;

`ifdef TX_DIFF_ENC_EN
    logic prev_i;
    logic prev_q;

    // The first symbol of a frame encodes against e[-1] = 0.
    assign e_i = b_i ^ (prev_i & ~first);
    assign e_q = b_q ^ (prev_q & ~first);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prev_i <= 1'b0;
            prev_q <= 1'b0;
        end else if (emit) begin
            prev_i <= e_i;
            prev_q <= e_q;
        end
    end
`else
    logic unused_first;

    assign e_i          = b_i;
    assign e_q          = b_q;
    assign unused_first = first;
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            dac_i <= '0;
            dac_q <= '0;
        end else if (emit) begin
            dac_i <= bit_to_amp(e_i, AMP);
            dac_q <= bpsk ? 12'sd0 : bit_to_amp(e_q, AMP);
        end
    end

endmodule

// File: rtl/psk_tx_framer.sv
// PSK transmit framer: preamble, sync word, payload, tail mapped to BPSK/QPSK
// samples held for SPS clocks. Differential encoding via TX_DIFF_ENC_EN.
module psk_tx_framer
    import psk_tx_pkg::*;
#(
    parameter int                 SPS          = 16,
    parameter int                 PREAMBLE_LEN = 4,
    parameter logic [15:0]        SYNC_WORD    = 16'hD391,
    parameter int                 TAIL_LEN     = 2,
    parameter logic signed [11:0] AMP          = 12'sd1024
) (
    input  logic               clk_16M384,
    input  logic               rst_16M384,
    input  logic               is_bpsk,
    psk_tx_framer_if.slave     s_axis,
    output logic signed [11:0] DAC_I,
    output logic signed [11:0] DAC_Q,
    output logic               sym_strobe,
    output logic               tx_busy,
    output logic               frame_start,
    output logic               underrun,
    output tx_state_e          dbg_state
);

    localparam int         CW        = $clog2(SPS);
    localparam logic [7:0] LAST_PRE  = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] LAST_TAIL = 8'(TAIL_LEN - 1);

    tx_state_e   state, state_n;
    logic [CW-1:0] sym_cnt;
    logic [15:0] shreg, shreg_n, unit, sel;
    logic [4:0]  bit_pos, bit_pos_n, bps, unit_len;
    logic [7:0]  byte_cnt, byte_cnt_n, hold, hold_n;
    logic        cur_last, cur_last_n, hold_last, hold_last_n;
    logic        hold_full, hold_full_n, last_acc, last_acc_n, mode, mode_n;
    logic        boundary, unit_done, tready, accept, sel_bpsk, load_unit;
    logic        emit, clear, strobe_n, frame_start_n, underrun_n;

    assign boundary  = (sym_cnt == CW'(SPS - 1));
    assign tready    = ~hold_full & ~last_acc &
                       (state == PREAMBLE || state == SYNC || state == PAYLOAD);
    assign accept    = s_axis.s_tvalid & tready;
    assign sel_bpsk  = (state == IDLE) ? is_bpsk : mode;
    assign bps       = sel_bpsk ? 5'd1 : 5'd2;
    assign unit_len  = (state == SYNC) ? 5'd16 : 5'd8;
    assign unit_done = (bit_pos == unit_len);

    assign s_axis.s_tready = tready;
    assign tx_busy         = (state != IDLE);
    assign dbg_state       = state;

    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        bit_pos_n     = bit_pos;
        byte_cnt_n    = byte_cnt;
        cur_last_n    = cur_last;
        hold_n        = hold;
        hold_last_n   = hold_last;
        hold_full_n   = hold_full;
        last_acc_n    = last_acc;
        mode_n        = mode;
        unit          = '0;
        sel           = shreg;
        load_unit     = 1'b0;
        emit          = 1'b0;
        clear         = 1'b0;
        strobe_n      = 1'b0;
        frame_start_n = 1'b0;
        underrun_n    = 1'b0;

        if (accept) begin
            hold_n      = s_axis.s_tdata;
            hold_last_n = s_axis.s_tlast;
            hold_full_n = 1'b1;
            if (s_axis.s_tlast) last_acc_n = 1'b1;
        end

        if (boundary) begin
            unique case (state)
                IDLE: if (s_axis.s_tvalid) begin
                    state_n       = PREAMBLE;
                    mode_n        = is_bpsk;
                    frame_start_n = 1'b1;
                    byte_cnt_n    = '0;
                    cur_last_n    = 1'b0;
                    load_unit     = 1'b1;
                    unit          = {PREAMBLE_BYTE, 8'h00};
                end
                PREAMBLE: if (unit_done) begin
                    load_unit = 1'b1;
                    if (byte_cnt == LAST_PRE) begin
                        state_n = SYNC;
                        unit    = SYNC_WORD;
                    end else begin
                        byte_cnt_n = byte_cnt + 8'd1;
                        unit       = {PREAMBLE_BYTE, 8'h00};
                    end
                end
                SYNC, PAYLOAD: if (unit_done) begin
                    load_unit = 1'b1;
                    if (state == PAYLOAD && cur_last) begin
                        state_n    = TAIL;
                        byte_cnt_n = '0;
                        unit       = {TAIL_BYTE, 8'h00};
                    end else if (hold_full) begin
                        state_n     = PAYLOAD;
                        unit        = {hold, 8'h00};
                        cur_last_n  = hold_last;
                        hold_full_n = 1'b0;
                    end else if (accept) begin
                        // Byte arriving exactly when its load is due bypasses the holding register.
                        state_n     = PAYLOAD;
                        unit        = {s_axis.s_tdata, 8'h00};
                        cur_last_n  = s_axis.s_tlast;
                        hold_full_n = 1'b0;
                    end else begin
                        state_n    = TAIL;
                        underrun_n = 1'b1;
                        byte_cnt_n = '0;
                        unit       = {TAIL_BYTE, 8'h00};
                    end
                end
                TAIL: if (unit_done) begin
                    if (byte_cnt == LAST_TAIL) begin
                        state_n = IDLE;
                    end else begin
                        load_unit  = 1'b1;
                        byte_cnt_n = byte_cnt + 8'd1;
                        unit       = {TAIL_BYTE, 8'h00};
                    end
                end
                default: state_n = IDLE;
            endcase

            if (state_n == IDLE) begin
                clear       = 1'b1;
                last_acc_n  = 1'b0;
                hold_full_n = 1'b0;
            end else begin
                emit      = 1'b1;
                strobe_n  = 1'b1;
                sel       = load_unit ? unit : shreg;
                shreg_n   = sel << bps;
                bit_pos_n = load_unit ? bps : bit_pos + bps;
            end
        end
    end

    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            state       <= IDLE;
            sym_cnt     <= '0;
            shreg       <= '0;
            bit_pos     <= '0;
            byte_cnt    <= '0;
            cur_last    <= 1'b0;
            hold        <= '0;
            hold_last   <= 1'b0;
            hold_full   <= 1'b0;
            last_acc    <= 1'b0;
            mode        <= 1'b0;
            sym_strobe  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_n;
            sym_cnt     <= boundary ? '0 : sym_cnt + 1'b1;
            shreg       <= shreg_n;
            bit_pos     <= bit_pos_n;
            byte_cnt    <= byte_cnt_n;
            cur_last    <= cur_last_n;
            hold        <= hold_n;
            hold_last   <= hold_last_n;
            hold_full   <= hold_full_n;
            last_acc    <= last_acc_n;
            mode        <= mode_n;
            sym_strobe  <= strobe_n;
            frame_start <= frame_start_n;
            underrun    <= underrun_n;
        end
    end

    psk_tx_mapper #(.AMP(AMP)) u_mapper (
        .clk   (clk_16M384),
        .rst   (rst_16M384),
        .emit  (emit),
        .clear (clear),
        .first (frame_start_n),
        .bpsk  (sel_bpsk),
        .b_i   (sel[15]),
        .b_q   (sel[14]),
        .dac_i (DAC_I),
        .dac_q (DAC_Q)
    );

endmodule
